// File: rtl/axis_vec_pkg.sv
// Shared types and arithmetic for the matrix-vector datapath: accumulator width
// helper and the requantisation reference used by both RTL and reference models.
package axis_vec_pkg;

  localparam int unsigned MAX_W = 64;

  typedef logic signed [MAX_W-1:0] wide_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ser_state_e;

  // Accumulator width produced by a C-deep dot product of W_X by W_K operands.
  function automatic int y_width(input int w_x, input int w_k, input int c);
    return w_x + w_k + $clog2(c);
  endfunction

  // Round-half-up arithmetic shift, optional ReLU, then saturation to signed w_o.
  // The 64-bit working width covers the W_Y+1 intermediate for any W_Y up to 62.
  function automatic wide_t requant(input wide_t y, input int shift, input bit relu,
                                    input int w_o);
    wide_t t;
    wide_t hi;
    wide_t lo;
    if (shift > 0) begin
      t = (y + (wide_t'(1) <<< (shift - 1))) >>> shift;
    end else begin
      t = y;
    end
    if (relu && t[MAX_W-1]) begin
      t = '0;
    end
    hi = (wide_t'(1) <<< (w_o - 1)) - wide_t'(1);
    lo = -(wide_t'(1) <<< (w_o - 1));
    if (t > hi) begin
      t = hi;
    end else if (t < lo) begin
      t = lo;
    end
    return t;
  endfunction

endpackage

// File: rtl/axis_vec_requant_serializer_requant_sat.sv
// Combinational requantiser for a single accumulator element.
module requant_sat
  import axis_vec_pkg::*;
#(
  parameter int W_Y   = 19,
  parameter int W_O   = 8,
  parameter int SHIFT = 8,
  parameter int RELU  = 1
) (
  input  logic [W_Y-1:0] y,
  output logic [W_O-1:0] z
);

  wide_t y_ext;

  always_comb begin
    y_ext = wide_t'($signed(y));
    z     = W_O'(requant(y_ext, SHIFT, (RELU != 0), W_O));
  end

endmodule

// File: rtl/axis_vec_requant_serializer.sv
// Takes one wide beat of R accumulators and streams them out as R requantised
// narrow beats, element 0 first, tlast on the final element.
module axis_vec_requant_serializer
  import axis_vec_pkg::*;
#(
  parameter int R     = 8,
  parameter int W_Y   = 19,
  parameter int W_O   = 8,
  parameter int SHIFT = 8,
  parameter int RELU  = 1
) (
  input  logic             clk,
  input  logic             rstn,
  output logic             s_axis_y_tready,
  input  logic             s_axis_y_tvalid,
  input  logic [R*W_Y-1:0] s_axis_y_tdata,
  input  logic             m_axis_z_tready,
  output logic             m_axis_z_tvalid,
  output logic [W_O-1:0]   m_axis_z_tdata,
  output logic             m_axis_z_tlast
);

  localparam int IDX_W = (R > 1) ? $clog2(R) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(R - 1);

  logic [R*W_Y-1:0] word_q, word_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;

  ser_state_e       state;
  logic             at_last;
  logic             in_fire;
  logic             out_fire;
  logic [W_Y-1:0]   elem;
  logic [W_O-1:0]   elem_z;

  assign state    = valid_q ? ST_SEND : ST_IDLE;
  assign at_last  = (idx_q == LAST_IDX);

  // Ready opens only when the last element leaves, so a new word lands with no bubble.
  assign s_axis_y_tready = !valid_q || (m_axis_z_tready && at_last);
  assign in_fire         = s_axis_y_tvalid && s_axis_y_tready;
  assign out_fire        = valid_q && m_axis_z_tready;

  always_comb begin
    elem = word_q[W_Y-1:0];
    for (int r = 0; r < R; r++) begin
      if (idx_q == IDX_W'(r)) begin
        elem = word_q[r*W_Y +: W_Y];
      end
    end
  end

  requant_sat #(
    .W_Y  (W_Y),
    .W_O  (W_O),
    .SHIFT(SHIFT),
    .RELU (RELU)
  ) u_requant (
    .y(elem),
    .z(elem_z)
  );

  always_comb begin
    word_d  = word_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    case (state)
      ST_IDLE: begin
        if (in_fire) begin
          word_d  = s_axis_y_tdata;
          idx_d   = '0;
          valid_d = 1'b1;
        end
      end
      ST_SEND: begin
        if (out_fire) begin
          if (!at_last) begin
            idx_d = idx_q + IDX_W'(1);
          end else if (in_fire) begin
            word_d = s_axis_y_tdata;
            idx_d  = '0;
          end else begin
            valid_d = 1'b0;
            idx_d   = '0;
          end
        end
      end
      default: begin
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      word_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      word_q  <= word_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  assign m_axis_z_tvalid = valid_q;
  assign m_axis_z_tdata  = valid_q ? elem_z : '0;
  assign m_axis_z_tlast  = valid_q && at_last;

endmodule

// File: doc/axis_vec_requant_serializer.md
Name: axis_vec_requant_serializer

Overview:
- Sits directly downstream of the matrix-vector multiplier.
- Accepts one wide AXI-Stream beat carrying R signed accumulator results (R*W_Y bits) and requantises each element: rounding arithmetic right shift, optional ReLU, saturation to signed W_O.
- Emits the R elements as R narrow beats, element 0 first, with tlast on element R-1.
- Its output feeds the next layer's vector loader.

Parameters:
- R, 8, number of elements per input beat (rows of the multiplier)
- W_Y, 19, signed accumulator width per element (W_X+W_K+clog2(C) for 8/8/8)
- W_O, 8, signed output element width
- SHIFT, 8, right-shift amount, 0..W_Y-1
- RELU, 1, 1 = clamp negative results to 0 before saturation

Ports:
- clk  input  1  clock
- rstn  input  1  asynchronous active-low reset
- s_axis_y_tready  output  1  input ready
- s_axis_y_tvalid  input  1  input valid
- s_axis_y_tdata  input  R*W_Y  packed elements, element r at bits [r*W_Y +: W_Y]
- m_axis_z_tready  input  1  output ready
- m_axis_z_tvalid  output  1  output valid
- m_axis_z_tdata  output  W_O  requantised element
- m_axis_z_tlast  output  1  high on element R-1

Behaviour:
- Registers:
  - word_q: R*W_Y bits
  - idx_q: clog2(R) bits
  - valid_q: 1 bit
- Async reset (rstn low): word_q=0, idx_q=0, valid_q=0.
  - Outputs during and after reset: m_axis_z_tvalid=0, m_axis_z_tlast=0, m_axis_z_tdata=0.
  - Source must hold tvalid low during reset. Handshakes while rstn is low are ignored.
- Output drive:
  - m_axis_z_tvalid = valid_q.
  - m_axis_z_tdata = requant(word_q[idx_q]) when valid_q, else 0.
  - m_axis_z_tlast = valid_q && idx_q==R-1.
  - All three are functions of registers only, so they are stable while valid and not ready.
- s_axis_y_tready = !valid_q || (m_axis_z_tready && idx_q==R-1). It is combinational from registers and m_axis_z_tready; it is never a function of s_axis_y_tvalid.
- Effective states:
  - IDLE (valid_q=0): input accept loads word_q, sets idx_q=0 and valid_q=1.
  - SEND (valid_q=1): on output handshake with idx_q<R-1, idx_q increments.
  - SEND, output handshake at idx_q==R-1 with simultaneous input accept: load new word, idx_q=0, valid_q stays 1. No bubble.
  - SEND, output handshake at idx_q==R-1 with no input: valid_q=0, idx_q=0.
- Latency: first output beat is valid the cycle after input accept.
- Throughput: one input beat per R cycles when the sink is always ready.
- requant(y), all arithmetic signed, intermediate width W_Y+1:
  - t = (SHIFT>0) ? (y + 2^(SHIFT-1)) >>> SHIFT : y. This is round-half-up, floor for negatives.
  - If RELU and t<0: t=0.
  - Saturate to [-2^(W_O-1), 2^(W_O-1)-1].
- Backpressure: m_axis_z_tready low holds idx_q and word_q unchanged for any number of cycles.
- Reset asserted mid-packet: packet is discarded; no partial beats after release.

Decomposition:
- Package axis_vec_pkg holds:
  - function y_width(W_X, W_K, C), returning the accumulator width shared with the multiplier
  - the requant function (inputs y, SHIFT, RELU, W_O) so the multiplier bench reference model reuses it
- One natural sub-module: requant_sat. It is combinational, single element, and instantiated once on the muxed element.
- Top holds the registers and handshake logic.

Test Plan:
- Rounding, defaults: one beat with elements {256, 383, 384, -1, 0, 127, 128, 32767} -> beats 1, 1, 2, 0, 0, 0, 1, 127; tlast only on beat 8.
- Saturation, RELU=0: elements -300, -40000, 40000 -> -1 (0xFF), -128 (0x80), 127 (0x7F). With RELU=1 the same elements -> 0, 0, 127.
- Back-to-back: 3 input beats, tvalid held high, sink always ready -> 24 consecutive output beats, no idle cycle. s_axis_y_tready high exactly in the cycles carrying element 7 (and the initial IDLE cycle).
- Random backpressure: 10% tvalid and 10% tready probability over 500 random words, checked against the package requant model -> exact match. tdata/tlast stable while tvalid && !tready.
- Reset mid-packet: assert rstn low after beat 3 of 8 -> m_axis_z_tvalid=0 and m_axis_z_tdata=0 immediately. After release, the next input yields a fresh 8-beat packet starting at element 0.
- SHIFT=0, W_O=19 variant: elements pass through unchanged, except negatives become 0 when RELU=1.
